// File: rtl/rip_branch_predictor_const.sv
// Shared encodings for the branch predictor: 2-bit saturating counter states.
package rip_branch_predictor_const;

    typedef enum logic [1:0] {
        STRONGLY_UNTAKEN = 2'd0,
        WEAKLY_UNTAKEN   = 2'd1,
        WEAKLY_TAKEN     = 2'd2,
        STRONGLY_TAKEN   = 2'd3
    } rip_bpw_t;

endpackage

// File: rtl/rip_branch_queue.sv
// In-order circular queue of in-flight branches; the caller guarantees push only
// when not full and pop only when not empty. Flush empties the queue at once.
module rip_branch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array carries no reset; occupancy is tracked by the
    // pointers and count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == DEPTH_C);

endmodule

// File: rtl/rip_branch_resolver.sv
// Tracks predicted conditional branches until execute resolves them, then emits
// the PHT update and, on a wrong prediction, a one-cycle flush with redirect PC.
module rip_branch_resolver
    import rip_branch_predictor_const::*;
#(
    parameter int PHT_LSB = 0,
    parameter int PHT_MSB = 31,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       push,
    input  logic [PHT_MSB-PHT_LSB:0]   push_index,
    input  rip_bpw_t                   push_weight,
    input  logic                       push_pred,
    input  logic [31:0]                push_pc,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       resolve,
    input  logic                       resolve_taken,
    input  logic [31:0]                resolve_target,
    output logic                       update,
    output logic [PHT_MSB-PHT_LSB:0]   update_index,
    output rip_bpw_t                   update_weight,
    output logic                       actual,
    output logic                       mispredict,
    output logic [31:0]                redirect_pc
);

    localparam int IW = PHT_MSB - PHT_LSB + 1;
    localparam int DW = IW + 2 + 1 + 32;

    logic [DW-1:0] push_data;
    logic [DW-1:0] head_data;
    logic [IW-1:0] head_index;
    rip_bpw_t      head_weight;
    logic          head_pred;
    logic [31:0]   head_pc;
    logic          push_ok;
    logic          pop_ok;
    logic          flush;

    assign push_data   = {push_index, push_weight, push_pred, push_pc};
    assign head_pc     = head_data[31:0];
    assign head_pred   = head_data[32];
    assign head_weight = rip_bpw_t'(head_data[34:33]);
    assign head_index  = head_data[DW-1:35];

    assign pop_ok  = resolve & (count != '0) & ~stall;
    assign flush   = pop_ok & (head_pred != resolve_taken);
    // A mispredicting pop discards the wrong-path push in the same cycle, and
    // the flush cycle itself (mispredict high) still carries wrong-path fetches.
    assign push_ok = push & ~full & ~stall & ~mispredict & ~flush;

    rip_branch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .pop       (pop_ok),
        .flush     (flush),
        .push_data (push_data),
        .head_data (head_data),
        .full      (full),
        .count     (count)
    );

    // NOTE: registered outputs use non-blocking assignments so every reader
    // sees the pre-edge values of the queue head and the resolve inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            update        <= 1'b0;
            update_index  <= '0;
            update_weight <= STRONGLY_UNTAKEN;
            actual        <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            update     <= pop_ok;
            mispredict <= flush;
            if (pop_ok) begin
                update_index  <= head_index;
                update_weight <= head_weight;
                actual        <= resolve_taken;
            end
            if (flush)
                redirect_pc <= resolve_taken ? resolve_target : head_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_rip_branch_resolver.sv
// Directed, table-driven bench for rip_branch_resolver with a hand-written
// stall/release sequence; each vector lists the state expected after its edge.
module tb_rip_branch_resolver;
    import rip_branch_predictor_const::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall, push, push_pred, resolve, resolve_taken;
    logic [7:0]  push_index;
    rip_bpw_t    push_weight;
    logic [31:0] push_pc, resolve_target;
    logic        full, update, actual, mispredict;
    logic [2:0]  count;
    logic [7:0]  update_index;
    rip_bpw_t    update_weight;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rip_branch_resolver #(.PHT_LSB(0), .PHT_MSB(7), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .push           (push),
        .push_index     (push_index),
        .push_weight    (push_weight),
        .push_pred      (push_pred),
        .push_pc        (push_pc),
        .full           (full),
        .count          (count),
        .resolve        (resolve),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .update         (update),
        .update_index   (update_index),
        .update_weight  (update_weight),
        .actual         (actual),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        rst, stall, push;
        logic [7:0]  idx;
        logic [1:0]  wt;
        logic        pred;
        logic [31:0] pc;
        logic        res, tk;
        logic [31:0] tgt;
        logic [2:0]  e_count;
        logic        e_full, e_upd;
        logic [7:0]  e_idx;
        logic [1:0]  e_wt;
        logic        e_act, e_misp;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst_i, stall_i, push_i, input logic [7:0] idx, input logic [1:0] wt,
        input logic pred, input logic [31:0] pc, input logic res, tk, input logic [31:0] tgt,
        input logic [2:0] ec, input logic ef, eu, input logic [7:0] eidx, input logic [1:0] ewt,
        input logic eact, emisp, input logic [31:0] erd);
        vec_t r;
        r.rst = rst_i; r.stall = stall_i; r.push = push_i; r.idx = idx; r.wt = wt;
        r.pred = pred; r.pc = pc; r.res = res; r.tk = tk; r.tgt = tgt;
        r.e_count = ec; r.e_full = ef; r.e_upd = eu; r.e_idx = eidx; r.e_wt = ewt;
        r.e_act = eact; r.e_misp = emisp; r.e_redir = erd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; stall = x.stall; push = x.push; push_index = x.idx;
        push_weight = rip_bpw_t'(x.wt); push_pred = x.pred; push_pc = x.pc;
        resolve = x.res; resolve_taken = x.tk; resolve_target = x.tgt;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));

        //     rst st ps idx wt pr pc            rs tk tgt          cnt f u eidx ewt ea em redirect
        vecs.push_back(v(1,0,1,8'h33,3,1,32'h0,       1,1,32'h0,       0,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,1,5, 2,1,32'h100,        0,0,32'h0,       1,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,1,32'h200,     0,0,1,5, 2,1,0,32'h0));
        vecs.push_back(v(0,0,1,7, 1,0,32'h40,         0,0,32'h0,       1,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,1,32'h80,      0,0,1,7, 1,1,1,32'h80));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          0,0,32'h0,       0,0,0,0, 0,0,0,32'h80));
        // resolve on an empty queue is ignored
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,0,32'hdead,    0,0,0,0, 0,0,0,32'h80));
        // not-taken redirect wraps modulo 2^32
        vecs.push_back(v(0,0,1,20,2,1,32'hFFFFFFFC,   0,0,32'h0,       1,0,0,0, 0,0,0,32'h80));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,0,32'h1234,    0,0,1,20,2,0,1,32'h0));
        vecs.push_back(v(0,0,1,9, 1,1,32'h50,         0,0,32'h0,       0,0,0,0, 0,0,0,32'h0));
        // three in flight, head mispredicts: flush plus same-cycle push dropped
        vecs.push_back(v(0,0,1,1, 3,1,32'h10,         0,0,32'h0,       1,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,1,2, 0,0,32'h20,         0,0,32'h0,       2,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,1,3, 2,1,32'h30,         0,0,32'h0,       3,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,1,4, 1,1,32'h40,         1,0,32'h999,     0,0,1,1, 3,0,1,32'h14));
        vecs.push_back(v(0,0,1,9, 1,1,32'h50,         0,0,32'h0,       0,0,0,0, 0,0,0,32'h14));
        // fill to DEPTH, overflow push, push+resolve while full
        vecs.push_back(v(0,0,1,10,2,1,32'h1000,       0,0,32'h0,       1,0,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,1,11,1,0,32'h1004,       0,0,32'h0,       2,0,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,1,12,3,1,32'h1008,       0,0,32'h0,       3,0,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,1,13,0,0,32'h100C,       0,0,32'h0,       4,1,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,1,14,2,1,32'h2000,       0,0,32'h0,       4,1,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,1,15,2,1,32'h1010,       1,1,32'h2000,    3,0,1,10,2,1,0,32'h14));
        vecs.push_back(v(0,0,1,16,1,0,32'h1014,       1,0,32'h0,       3,0,1,11,1,0,0,32'h14));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,1,32'h3000,    2,0,1,12,3,1,0,32'h14));
        // stall blocks resolve and push
        vecs.push_back(v(0,1,1,30,0,1,32'h700,        1,0,32'h0,       2,0,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,1,1,30,0,1,32'h700,        1,0,32'h0,       2,0,0,0, 0,0,0,32'h14));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,0,32'h0,       1,0,1,13,0,0,0,32'h14));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,1,32'h4444,    0,0,1,16,1,1,1,32'h4444));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          0,0,32'h0,       0,0,0,0, 0,0,0,32'h4444));
        // reset with three in flight and a resolve pending
        vecs.push_back(v(0,0,1,21,1,1,32'h500,        0,0,32'h0,       1,0,0,0, 0,0,0,32'h4444));
        vecs.push_back(v(0,0,1,22,1,1,32'h504,        0,0,32'h0,       2,0,0,0, 0,0,0,32'h4444));
        vecs.push_back(v(0,0,1,23,1,1,32'h508,        0,0,32'h0,       3,0,0,0, 0,0,0,32'h4444));
        vecs.push_back(v(1,1,1,24,1,1,32'h50C,        1,0,32'h0,       0,0,0,0, 0,0,0,32'h0));
        vecs.push_back(v(0,0,0,0, 0,0,32'h0,          1,1,32'h0,       0,0,0,0, 0,0,0,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("v%0d.update", i), 32'(update), 32'(vecs[i].e_upd));
            check($sformatf("v%0d.mispredict", i), 32'(mispredict), 32'(vecs[i].e_misp));
            check($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].e_redir);
            if (vecs[i].e_upd) begin
                check($sformatf("v%0d.update_index", i), 32'(update_index), 32'(vecs[i].e_idx));
                check($sformatf("v%0d.update_weight", i), 32'(update_weight), 32'(vecs[i].e_wt));
                check($sformatf("v%0d.actual", i), 32'(actual), 32'(vecs[i].e_act));
            end
        end

        // Long stall with resolve held, then a bounded wait for the first update.
        drive(v(0,0,1,40,3,1,32'h800, 0,0,32'h0, 0,0,0,0,0,0,0,0));
        step();
        drive(v(0,0,1,41,2,1,32'h804, 0,0,32'h0, 0,0,0,0,0,0,0,0));
        step();
        drive(v(0,1,0,0,0,0,32'h0, 1,1,32'h0, 0,0,0,0,0,0,0,0));
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall%0d.update", c), 32'(update), 32'd0);
            check($sformatf("stall%0d.count", c), 32'(count), 32'd2);
        end
        stall = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                step();
                seen = update;
            end
            check("release.update_seen", 32'(seen), 32'd1);
        end
        check("release.update_index", 32'(update_index), 32'd40);
        check("release.update_weight", 32'(update_weight), 32'(STRONGLY_TAKEN));
        check("release.count", 32'(count), 32'd1);
        step();
        check("second.update_index", 32'(update_index), 32'd41);
        check("second.update", 32'(update), 32'd1);
        check("second.count", 32'(count), 32'd0);
        resolve = 1'b0;
        step();
        check("idle.update", 32'(update), 32'd0);
        check("idle.mispredict", 32'(mispredict), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rip_branch_resolver.md
RIP_BRANCH_RESOLVER -- requirements
Module: rip_branch_resolver

Interface
REQ-001 SHALL have parameter PHT_LSB, default 0, LSB of PC bits forming the PHT index.
REQ-002 SHALL have parameter PHT_MSB, default 31, MSB of PC bits forming the PHT index; IW = PHT_MSB-PHT_LSB+1.
REQ-003 SHALL have parameter DEPTH, default 4, in-flight branch queue entries; power of two, >=2.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
 clk  in  1  clock, all logic on posedge
 rst  in  1  synchronous active-high reset
 stall  in  1  pipeline stall; blocks push, resolve and update
 push  in  1  fetch predicted a conditional branch
 push_index  in  IW  PHT index used for the prediction
 push_weight  in  rip_bpw_t  counter value read at prediction
 push_pred  in  1  predicted direction (1 = taken)
 push_pc  in  32  branch PC
 full  out  1  queue holds DEPTH entries
 count  out  $clog2(DEPTH)+1  occupied entries
 resolve  in  1  oldest in-flight branch resolved in execute
 resolve_taken  in  1  actual direction
 resolve_target  in  32  actual taken target
 update  out  1  PHT write strobe to predictor
 update_index  out  IW  PHT write address
 update_weight  out  rip_bpw_t  old counter value for saturating update
 actual  out  1  actual direction to predictor
 mispredict  out  1  one-cycle flush request
 redirect_pc  out  32  correct fetch PC on mispredict

Function
REQ-005 SHALL store {index, weight, pred, pc} per entry in an in-order circular queue with read/write pointers wrapping modulo DEPTH.
REQ-006 SHALL accept a push when push & ~full & ~stall & ~mispredict_pending; otherwise the push is dropped.
REQ-007 SHALL pop the head when resolve & (count!=0) & ~stall; resolve with count==0 SHALL be ignored with no output change.
REQ-008 SHALL drive full combinationally as count==DEPTH; simultaneous push and resolve while full SHALL pop only (push dropped).
REQ-009 SHALL, on simultaneous accepted push and pop without mispredict, keep count unchanged and advance both pointers.
REQ-010 SHALL register outputs: the cycle after a pop, update=1, update_index/update_weight = head entry, actual = resolve_taken; update SHALL be 0 in every other cycle.
REQ-011 SHALL assert mispredict for exactly one cycle, in the same cycle as the resulting update, when head pred != resolve_taken.
REQ-012 SHALL set redirect_pc on mispredict to resolve_target if taken, else head pc + 32'd4 (modulo 2^32); redirect_pc holds its value otherwise.
REQ-013 SHALL, on a mispredicting pop, flush all remaining entries at the same edge (count -> 0, pointers equal), and drop a push presented in that cycle.
REQ-014 SHALL drop any push in the cycle mispredict is high (mispredict_pending = mispredict output).
REQ-015 SHALL hold queue contents, pointers and redirect_pc during stall; update and mispredict SHALL be 0 in a stalled cycle.

Reset
REQ-016 SHALL on rst clear pointers, count=0, full=0, update=0, update_index=0, update_weight=STRONGLY_UNTAKEN, actual=0, mispredict=0, redirect_pc=0.
REQ-017 SHALL let rst override stall, push and resolve in the same cycle; entries in flight at reset SHALL be discarded without update.

Structure
REQ-018 SHALL import rip_bpw_t and STRONGLY_UNTAKEN..STRONGLY_TAKEN (0..3) from rip_branch_predictor_const; no new package typedefs.
REQ-019 SHALL implement the queue as one sub-module rip_branch_queue (parameter DEPTH, data width IW+2+1+32, flush input); resolve/compare logic stays in the top.

Verification
REQ-020 Push {idx=5, WT, pred=1, pc=0x100}; resolve taken, target 0x200 -> next cycle update=1, index=5, weight=WT, actual=1, mispredict=0.
REQ-021 Push {idx=7, WU, pred=0, pc=0x40}; resolve taken, target 0x80 -> mispredict=1 one cycle, redirect_pc=0x80, actual=1.
REQ-022 Push 3 entries, first pred=1, pc=0x10; resolve not-taken -> mispredict, redirect_pc=0x14, count=0; a same-cycle push is dropped.
REQ-023 Push DEPTH entries -> full=1; extra push dropped; push+resolve together -> count=DEPTH-1, full=0.
REQ-024 Hold stall=1 with resolve=1 and count=2 -> no update, count stays 2; release -> pop proceeds.
REQ-025 Assert rst with count=3 and resolve=1 -> next cycle count=0, update=0, mispredict=0, redirect_pc=0.
